// File: rtl/filter_dac_tx.sv
// Serialises fixed-point filter samples into 16-bit offset-binary frames for a
// 12-bit SPI-style DAC: sync_n low for the frame, sclk idles high, MSB first.
module filter_dac_tx #(
    parameter int largo = 24,
    parameter int FRAC  = 16,
    parameter int DIV   = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [largo:0] data_i,
    input  logic           valid_i,
    output logic           busy_o,
    output logic           done_o,
    output logic           overrun_o,
    output logic           sync_n_o,
    output logic           sclk_o,
    output logic           sdata_o,
    output logic [1:0]     state_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    localparam int              W        = largo + 1;
    localparam int              SH       = FRAC - 11;
    localparam logic [7:0]      DIV_LAST = 8'(DIV - 1);
    localparam logic signed [largo:0] S_MAX = W'(2047);
    localparam logic signed [largo:0] S_MIN = W'(-2048);

    logic [1:0]  state_q, state_d;
    logic [15:0] shift_q, shift_d;
    logic [3:0]  bit_q, bit_d;
    logic [7:0]  div_q, div_d;
    logic        sclk_q, sclk_d;
    logic        sync_n_q, sync_n_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        overrun_q, overrun_d;

    logic signed [largo:0] s_shift;
    logic [11:0]           code_c;
    logic [15:0]           word_c;

    // Scale to 12 integer bits, saturate, then flip the sign bit for offset binary.
    assign s_shift = $signed(data_i) >>> SH;

    always_comb begin
        code_c = {~s_shift[11], s_shift[10:0]};
        if (s_shift > S_MAX) begin
            code_c = 12'hFFF;
        end else if (s_shift < S_MIN) begin
            code_c = 12'h000;
        end
    end

    assign word_c = {4'b0000, code_c};

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        div_d     = div_q;
        sclk_d    = sclk_q;
        sync_n_d  = sync_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;
        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    state_d  = S_SHIFT;
                    shift_d  = word_c;
                    sync_n_d = 1'b0;
                    busy_d   = 1'b1;
                    bit_d    = 4'd0;
                    div_d    = 8'd0;
                end
            end
            S_SHIFT: begin
                if (valid_i) overrun_d = 1'b1;
                if (div_q == DIV_LAST) begin
                    div_d  = 8'd0;
                    sclk_d = ~sclk_q;
                    // sclk currently low means this toggle is a rising edge.
                    if (!sclk_q) begin
                        if (bit_q == 4'd15) begin
                            state_d  = S_GAP;
                            sync_n_d = 1'b1;
                            shift_d  = 16'h0000;
                            bit_d    = 4'd0;
                        end else begin
                            shift_d = {shift_q[14:0], 1'b0};
                            bit_d   = bit_q + 4'd1;
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            S_GAP: begin
                if (valid_i) overrun_d = 1'b1;
                if (div_q == DIV_LAST) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    div_d   = 8'd0;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: begin
                state_d  = S_IDLE;
                shift_d  = 16'h0000;
                sclk_d   = 1'b1;
                sync_n_d = 1'b1;
                busy_d   = 1'b0;
                bit_d    = 4'd0;
                div_d    = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            shift_q   <= 16'h0000;
            bit_q     <= 4'd0;
            div_q     <= 8'd0;
            sclk_q    <= 1'b1;
            sync_n_q  <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            div_q     <= div_d;
            sclk_q    <= sclk_d;
            sync_n_q  <= sync_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    // The shift register is zero outside a frame, so its MSB doubles as sdata.
    assign sdata_o   = shift_q[15];
    assign sclk_o    = sclk_q;
    assign sync_n_o  = sync_n_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign overrun_o = overrun_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_filter_dac_tx.sv
// Bench for filter_dac_tx: a serial monitor rebuilds each frame from sclk
// falling edges and compares it against words queued when samples are sent.
module tb_filter_dac_tx;

    localparam int LARGO = 24;
    localparam int FRAC  = 16;
    localparam int DIV   = 2;

    logic           clk;
    logic           rst;
    logic [LARGO:0] data_i;
    logic           valid_i;
    logic           busy_o;
    logic           done_o;
    logic           overrun_o;
    logic           sync_n_o;
    logic           sclk_o;
    logic           sdata_o;
    logic [1:0]     state_o;

    int checks;
    int errors;
    int frames_sent;
    int frames_seen;

    logic [15:0] exp_q[$];

    filter_dac_tx #(.largo(LARGO), .FRAC(FRAC), .DIV(DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .overrun_o (overrun_o),
        .sync_n_o  (sync_n_o),
        .sclk_o    (sclk_o),
        .sdata_o   (sdata_o),
        .state_o   (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference conversion: floor-divide by 2^(FRAC-11), clamp, offset by 2048.
    function automatic logic [15:0] model(input logic [LARGO:0] d);
        longint s;
        logic [11:0] code;
        s = longint'($signed(d));
        s = s >>> (FRAC - 11);
        if (s > 2047) s = 2047;
        if (s < -2048) s = -2048;
        code = 12'(s + 2048);
        return {4'b0000, code};
    endfunction

    task automatic send(input logic [LARGO:0] d, input logic [15:0] e);
        @(negedge clk);
        data_i  = d;
        valid_i = 1'b1;
        exp_q.push_back(e);
        frames_sent++;
        @(negedge clk);
        valid_i = 1'b0;
        data_i  = $urandom;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_o || done_o) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    // Serial monitor
    logic        prev_sclk, prev_sync, prev_sdata;
    logic        in_frame, awaiting;
    logic [15:0] word;
    int          nbits, low_cycles, since;

    always @(negedge clk) begin
        if (!rst) begin
            in_frame   = 1'b0;
            awaiting   = 1'b0;
            prev_sclk  = 1'b1;
            prev_sync  = 1'b1;
            prev_sdata = 1'b0;
        end else begin
            if (sync_n_o) chk("sclk_idle_high", 32'(sclk_o), 32'd1);
            if (awaiting) since++;
            if (done_o) begin
                if (awaiting) begin
                    chk("done_delay", since, DIV);
                    awaiting = 1'b0;
                end else begin
                    chk("spurious_done", 32'd1, 32'd0);
                end
            end else if (awaiting && since > DIV) begin
                chk("done_missing", 32'd0, 32'd1);
                awaiting = 1'b0;
            end
            if (prev_sync && !sync_n_o) begin
                in_frame   = 1'b1;
                nbits      = 0;
                low_cycles = 0;
                word       = 16'h0000;
            end
            if (in_frame && !sync_n_o) low_cycles++;
            if (in_frame && prev_sclk && !sclk_o) begin
                chk("sdata_stable", 32'(sdata_o), 32'(prev_sdata));
                word = {word[14:0], sdata_o};
                nbits++;
            end
            if (in_frame && !prev_sync && sync_n_o) begin
                in_frame = 1'b0;
                chk("frame_bits", nbits, 16);
                chk("sync_low_cycles", low_cycles, 32 * DIV);
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 32'(word), 32'hFFFF_FFFF);
                end else begin
                    chk("frame_word", 32'(word), 32'(exp_q.pop_front()));
                end
                awaiting = 1'b1;
                since    = 0;
                frames_seen++;
            end
            prev_sclk  = sclk_o;
            prev_sync  = sync_n_o;
            prev_sdata = sdata_o;
        end
    end

    initial begin
        logic [LARGO:0] d;
        int n;
        checks = 0;
        errors = 0;
        frames_sent = 0;
        frames_seen = 0;
        rst     = 1'b0;
        valid_i = 1'b0;
        data_i  = '0;
        repeat (3) @(negedge clk);
        chk("rst_sync_n", 32'(sync_n_o), 32'd1);
        chk("rst_sclk", 32'(sclk_o), 32'd1);
        chk("rst_sdata", 32'(sdata_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_overrun", 32'(overrun_o), 32'd0);
        chk("rst_state", 32'(state_o), 32'd0);
        rst = 1'b1;

        // Directed conversion vectors
        send(25'h0000000, 16'h0800);
        chk("busy_after_accept", 32'(busy_o), 32'd1);
        wait_idle();
        send(25'h0008000, 16'h0C00);
        wait_idle();
        send(25'h0FFFFFF, 16'h0FFF);
        wait_idle();
        send(25'h1000000, 16'h0000);
        wait_idle();

        // Random samples, spread over in-range and saturating magnitudes
        for (int i = 0; i < 6; i++) begin
            d = 25'($urandom);
            if (i < 3) d = 25'($signed(17'($urandom_range(0, 131071))));
            send(d, model(d));
            wait_idle();
        end

        // Overrun: sample arriving around bit 7 must be dropped
        chk("overrun_before", 32'(overrun_o), 32'd0);
        send(25'h0004000, 16'h0A00);
        repeat (2 * DIV * 7) @(negedge clk);
        data_i  = 25'h0FFFFFF;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        wait_idle();
        chk("overrun_set", 32'(overrun_o), 32'd1);
        repeat (4) @(negedge clk);
        chk("overrun_sticky", 32'(overrun_o), 32'd1);

        // Back-to-back: second sample in the done cycle
        send(25'h1FF0000, model(25'h1FF0000));
        n = 0;
        while (!done_o && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("done_timeout", 32'd0, 32'd1);
        data_i  = 25'h0012345;
        valid_i = 1'b1;
        exp_q.push_back(model(25'h0012345));
        frames_sent++;
        @(negedge clk);
        valid_i = 1'b0;
        chk("b2b_sync_low", 32'(sync_n_o), 32'd0);
        wait_idle();

        // Reset mid-frame around bit 10
        send(25'h0007000, model(25'h0007000));
        repeat (2 * DIV * 10) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_sync_n", 32'(sync_n_o), 32'd1);
        chk("abort_sclk", 32'(sclk_o), 32'd1);
        chk("abort_sdata", 32'(sdata_o), 32'd0);
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_done", 32'(done_o), 32'd0);
        chk("abort_overrun", 32'(overrun_o), 32'd0);
        chk("abort_state", 32'(state_o), 32'd0);
        exp_q.delete();
        frames_sent--;
        repeat (2) @(negedge clk);
        rst     = 1'b1;
        data_i  = 25'h1FFC000;
        valid_i = 1'b1;
        exp_q.push_back(model(25'h1FFC000));
        frames_sent++;
        @(negedge clk);
        valid_i = 1'b0;
        chk("post_rst_accept", 32'(sync_n_o), 32'd0);
        wait_idle();

        repeat (5) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("frame_count", frames_seen, frames_sent);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1);
    end

endmodule
